apb_cmd_master: RTL and testbench

APB initiator that turns a simple valid/ready command stream into single APB3 transfers, then returns read data and status on a valid/ready response channel. It is the driving end of the APB slave port on pwm_controller. It is used in FPGA/board integration behind a host command source (UART/JTAG bridge or soft CPU shim). Exactly one transfer is outstanding at a time, and a programmable watchdog aborts transfers when the slave never asserts pready.

---
 rtl/apb_cmd_master.sv | 126 ++++++++++++
 tb/tb_apb_cmd_master.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_cmd_master.sv
// apb_cmd_master
//   Turns a valid/ready command stream into single APB3 transfers and returns
//   read data plus status on a valid/ready response channel. Only one transfer
//   is in flight at a time. A watchdog aborts a transfer when the slave holds
//   pready low for TIMEOUT_CYCLES ACCESS cycles (TIMEOUT_CYCLES = 0 disables it).
//
// Ports
//   pclk_i, preset_i          clock, asynchronous active-high reset
//   cmd_valid_i/cmd_ready_o   command handshake (ready only in IDLE)
//   cmd_write_i/addr/wdata    command fields
//   rsp_valid_o/rsp_ready_i   response handshake
//   rsp_rdata_o               read data (0 for writes and timeouts)
//   rsp_err_o                 pslverr seen or watchdog abort
//   rsp_timeout_o             watchdog abort
//   psel_o..pwdata_o          APB request side (registered)
//   prdata_i/pready_i/pslverr_i  APB completion side
//   busy_o                    high whenever the FSM is not IDLE
module apb_cmd_master #(
   parameter int ADDR_WIDTH     = 12,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TO_WIDTH       = 8
) (
   input  logic                  pclk_i,
   input  logic                  preset_i,
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic                  cmd_write_i,
   input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
   input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [DATA_WIDTH-1:0] rsp_rdata_o,
   output logic                  rsp_err_o,
   output logic                  rsp_timeout_o,
   output logic                  psel_o,
   output logic                  penable_o,
   output logic                  pwrite_o,
   output logic [ADDR_WIDTH-1:0] paddr_o,
   output logic [DATA_WIDTH-1:0] pwdata_o,
   input  logic [DATA_WIDTH-1:0] prdata_i,
   input  logic                  pready_i,
   input  logic                  pslverr_i,
   output logic                  busy_o
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   localparam bit                TO_EN   = (TIMEOUT_CYCLES != 0);
   // Watchdog value on the last permitted ACCESS cycle; unused when disabled.
   localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);

   state_t              state;
   logic [TO_WIDTH-1:0] wdog;

   // Only combinational output; held low while reset is asserted.
   assign cmd_ready_o = (state == IDLE) && !preset_i;

   always_ff @(posedge pclk_i or posedge preset_i) begin
      if (preset_i) begin
         state         <= IDLE;
         psel_o        <= 1'b0;
         penable_o     <= 1'b0;
         pwrite_o      <= 1'b0;
         paddr_o       <= '0;
         pwdata_o      <= '0;
         rsp_valid_o   <= 1'b0;
         rsp_rdata_o   <= '0;
         rsp_err_o     <= 1'b0;
         rsp_timeout_o <= 1'b0;
         busy_o        <= 1'b0;
         wdog          <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid_i && cmd_ready_o) begin
                  pwrite_o  <= cmd_write_i;
                  paddr_o   <= cmd_addr_i;
                  pwdata_o  <= cmd_wdata_i;
                  psel_o    <= 1'b1;
                  penable_o <= 1'b0;
                  busy_o    <= 1'b1;
                  state     <= SETUP;
               end
            end
            SETUP: begin
               penable_o <= 1'b1;
               wdog      <= '0;
               state     <= ACCESS;
            end
            ACCESS: begin
               // pready on the final allowed cycle takes priority over abort.
               if (pready_i) begin
                  psel_o        <= 1'b0;
                  penable_o     <= 1'b0;
                  rsp_rdata_o   <= pwrite_o ? '0 : prdata_i;
                  rsp_err_o     <= pslverr_i;
                  rsp_timeout_o <= 1'b0;
                  rsp_valid_o   <= 1'b1;
                  state         <= RESP;
               end else if (TO_EN && (wdog == TO_LAST)) begin
                  psel_o        <= 1'b0;
                  penable_o     <= 1'b0;
                  rsp_rdata_o   <= '0;
                  rsp_err_o     <= 1'b1;
                  rsp_timeout_o <= 1'b1;
                  rsp_valid_o   <= 1'b1;
                  state         <= RESP;
               end else begin
                  wdog <= wdog + 1'b1;
               end
            end
            RESP: begin
               // Response fields stay put after the handshake until overwritten.
               if (rsp_ready_i) begin
                  rsp_valid_o <= 1'b0;
                  busy_o      <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master (TIMEOUT_CYCLES = 4). A simple APB slave answers
// after a programmable number of wait states; expected results come from a
// table of hand-derived vectors, a transfer-level model for random traffic,
// and scripted sequences for backpressure and mid-transfer reset.
module tb_apb_cmd_master;

   localparam int AW = 12;
   localparam int DW = 32;
   localparam int TO = 4;

   logic          pclk = 1'b0;
   logic          preset = 1'b1;
   logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
   logic [AW-1:0] cmd_addr = '0;
   logic [DW-1:0] cmd_wdata = '0;
   logic          rsp_valid, rsp_ready = 1'b0, rsp_err, rsp_timeout;
   logic [DW-1:0] rsp_rdata;
   logic          psel, penable, pwrite, pready, pslverr, busy;
   logic [AW-1:0] paddr;
   logic [DW-1:0] pwdata, prdata;

   // slave model knobs
   int            slv_wait = 0;
   logic [DW-1:0] slv_rdata = '0;
   logic          slv_err = 1'b0;
   int            acc_cnt;

   int n_chk = 0, n_pass = 0;

   always #5 pclk = ~pclk;

   apb_cmd_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO), .TO_WIDTH(8)) dut (
      .pclk_i(pclk), .preset_i(preset),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
      .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
      .rsp_err_o(rsp_err), .rsp_timeout_o(rsp_timeout),
      .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite), .paddr_o(paddr),
      .pwdata_o(pwdata), .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr),
      .busy_o(busy));

   // Slave: pready on ACCESS cycle number slv_wait+1.
   assign pready  = psel && penable && (acc_cnt == slv_wait);
   assign prdata  = slv_rdata;
   assign pslverr = slv_err;
   always @(posedge pclk or posedge preset)
      if (preset) acc_cnt <= 0;
      else if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
      else acc_cnt <= 0;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge pclk); #1;
   endtask

   typedef struct {
      int            k;      // ACCESS cycles
      logic [DW-1:0] rdata;
      logic          err;
      logic          to;
   } exp_t;

   // Transfer-level reference: slave answers after w wait states unless the
   // watchdog budget of TO ACCESS cycles runs out first.
   function automatic exp_t model(logic wr, int w, logic [DW-1:0] rd, logic se);
      exp_t e;
      if (w + 1 <= TO) begin
         e.k = w + 1; e.rdata = wr ? '0 : rd; e.err = se; e.to = 1'b0;
      end else begin
         e.k = TO; e.rdata = '0; e.err = 1'b1; e.to = 1'b1;
      end
      return e;
   endfunction

   // Entry: 1ns after a rising edge, DUT idle. Runs one transfer end to end.
   task automatic do_txn(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int w, input logic [DW-1:0] rd, input logic se,
                         input int hold, input exp_t e);
      int cyc = 0, ps = 0, pe = 0;
      bit bad = 0, hbad = 0;
      slv_wait = w; slv_rdata = rd; slv_err = se;
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
      chk("cmd_ready_idle", cmd_ready, 1);
      while (!rsp_valid && cyc < 40) begin
         if (psel) ps++;
         if (penable) pe++;
         if (psel && (paddr !== a || pwrite !== wr || (wr && pwdata !== d))) bad = 1;
         if (penable && !psel) bad = 1;
         if (cyc > 0 && cmd_ready) bad = 1;
         step(); cyc++;
         if (cyc == 1) begin
            cmd_valid = 1'b0; cmd_addr = AW'($urandom); cmd_wdata = $urandom;
         end
      end
      chk("rsp_valid_seen", rsp_valid, 1);
      chk("latency", cyc, 2 + e.k);
      chk("psel_cycles", ps, e.k + 1);
      chk("penable_cycles", pe, e.k);
      chk("bus_protocol", bad, 0);
      chk("rsp_rdata", rsp_rdata, e.rdata);
      chk("rsp_err", rsp_err, e.err);
      chk("rsp_timeout", rsp_timeout, e.to);
      chk("psel_released", psel, 0);
      chk("busy_resp", busy, 1);
      slv_rdata = $urandom; slv_err = ~slv_err;
      for (int i = 0; i < hold; i++) begin
         step();
         if (!rsp_valid || rsp_rdata !== e.rdata || rsp_err !== e.err ||
             rsp_timeout !== e.to || psel || cmd_ready) hbad = 1;
      end
      if (hold > 0) chk("rsp_hold", hbad, 0);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk("rsp_valid_clr", rsp_valid, 0);
      chk("cmd_ready_back", cmd_ready, 1);
      chk("busy_clr", busy, 0);
      chk("rdata_kept", rsp_rdata, e.rdata);
   endtask

   typedef struct {
      logic          wr;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      int            w;
      logic [DW-1:0] rd;
      logic          se;
      int            hold;
      exp_t          e;
   } vec_t;

   initial begin
      vec_t vecs[7];
      exp_t e;
      bit   bad;
      int   cyc;

      vecs[0] = '{1'b0, 12'h004, 32'h0,        0, 32'hDEADBEEF, 1'b0, 0, '{1, 32'hDEADBEEF, 1'b0, 1'b0}};
      vecs[1] = '{1'b1, 12'h010, 32'h000000FF, 3, 32'h12345678, 1'b0, 2, '{4, 32'h0,        1'b0, 1'b0}};
      vecs[2] = '{1'b0, 12'h020, 32'h0,        0, 32'hCAFEF00D, 1'b1, 1, '{1, 32'hCAFEF00D, 1'b1, 1'b0}};
      vecs[3] = '{1'b0, 12'h030, 32'h0,        9, 32'h00000055, 1'b0, 0, '{4, 32'h0,        1'b1, 1'b1}};
      vecs[4] = '{1'b0, 12'h040, 32'h0,        3, 32'hA5A5A5A5, 1'b0, 0, '{4, 32'hA5A5A5A5, 1'b0, 1'b0}};
      vecs[5] = '{1'b1, 12'hFFF, 32'hFFFFFFFF, 0, 32'h11111111, 1'b1, 3, '{1, 32'h0,        1'b1, 1'b0}};
      vecs[6] = '{1'b1, 12'h0A8, 32'h87654321, 7, 32'h22222222, 1'b0, 0, '{4, 32'h0,        1'b1, 1'b1}};

      // reset state
      repeat (3) step();
      chk("rst_psel", psel, 0);
      chk("rst_penable", penable, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_paddr", paddr, 0);
      chk("rst_rdata", rsp_rdata, 0);
      chk("rst_err_to", {rsp_err, rsp_timeout}, 0);
      preset = 1'b0;
      step();

      foreach (vecs[i])
         do_txn(vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].w, vecs[i].rd,
                vecs[i].se, vecs[i].hold, vecs[i].e);

      // random traffic against the transfer-level model
      for (int n = 0; n < 40; n++) begin
         logic          wr = 1'($urandom);
         logic [AW-1:0] a  = AW'($urandom);
         logic [DW-1:0] d  = $urandom;
         int            w  = $urandom_range(0, 6);
         logic [DW-1:0] rd = $urandom;
         logic          se = 1'($urandom);
         e = model(wr, w, rd, se);
         do_txn(wr, a, d, w, rd, se, $urandom_range(0, 2), e);
      end

      // backpressure with cmd_valid held, then back-to-back command
      slv_wait = 0; slv_rdata = 32'h0BADF00D; slv_err = 1'b0;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h100;
      cyc = 0;
      while (!rsp_valid && cyc < 20) begin step(); cyc++; end
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_latency", cyc, 3);
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (psel || cmd_ready || !rsp_valid || rsp_rdata !== 32'h0BADF00D) bad = 1;
      end
      chk("bp_hold", bad, 0);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk("b2b_gap_psel", psel, 0);
      chk("b2b_cmd_ready", cmd_ready, 1);
      cmd_addr = 12'h104; slv_rdata = 32'h600DCAFE;
      step();
      cmd_valid = 1'b0;
      chk("b2b_psel", psel, 1);
      chk("b2b_paddr", paddr, 12'h104);
      cyc = 0;
      while (!rsp_valid && cyc < 20) begin step(); cyc++; end
      chk("b2b_rdata", rsp_rdata, 32'h600DCAFE);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;

      // reset in the middle of ACCESS
      slv_wait = 9;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h200; cmd_wdata = 32'h1;
      step();
      cmd_valid = 1'b0;
      step(); step();
      chk("pre_rst_penable", penable, 1);
      #2 preset = 1'b1;
      #1;
      chk("mid_rst_bus", {psel, penable}, 0);
      chk("mid_rst_rsp_busy", {rsp_valid, busy}, 0);
      chk("mid_rst_cmd_ready", cmd_ready, 0);
      step();
      preset = 1'b0;
      step();
      chk("post_rst_cmd_ready", cmd_ready, 1);
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         if (rsp_valid || psel) bad = 1;
         step();
      end
      chk("post_rst_quiet", bad, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
